// File: rtl/core_pkg.sv
// Shared types and constants for the core sequencer and the opcode classifier.
package core_pkg;

  localparam int XLEN = 32;
  localparam int OPW  = 6;
  localparam int REGW = 5;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEMORY,
    ST_WRITEBACK,
    ST_HALT
  } state_t;

  localparam logic [OPW-1:0] OP_R    = 6'd0;
  localparam logic [OPW-1:0] OP_ADDI = 6'd1;
  localparam logic [OPW-1:0] OP_LUI  = 6'd3;
  localparam logic [OPW-1:0] OP_ANDI = 6'd4;
  localparam logic [OPW-1:0] OP_ORI  = 6'd5;
  localparam logic [OPW-1:0] OP_XORI = 6'd6;
  localparam logic [OPW-1:0] OP_LW   = 6'd16;
  localparam logic [OPW-1:0] OP_LH   = 6'd18;
  localparam logic [OPW-1:0] OP_LB   = 6'd20;
  localparam logic [OPW-1:0] OP_SW   = 6'd24;
  localparam logic [OPW-1:0] OP_SH   = 6'd26;
  localparam logic [OPW-1:0] OP_SB   = 6'd28;
  localparam logic [OPW-1:0] OP_BEQ  = 6'd32;
  localparam logic [OPW-1:0] OP_BNE  = 6'd33;
  localparam logic [OPW-1:0] OP_BLT  = 6'd34;
  localparam logic [OPW-1:0] OP_BLE  = 6'd35;
  localparam logic [OPW-1:0] OP_J    = 6'd40;
  localparam logic [OPW-1:0] OP_JAL  = 6'd41;
  localparam logic [OPW-1:0] OP_JR   = 6'd42;
  localparam logic [OPW-1:0] OP_HALT = 6'd63;

endpackage

// File: rtl/core_sequencer_op_classify.sv
// Opcode classifier: sorts a 6-bit opcode into load / store / writeback / halt.
// Anything outside these groups (branches, jumps, undefined) reports all zeros.
module op_classify
  import core_pkg::*;
(
  input  logic [OPW-1:0] op,
  output logic           is_load,
  output logic           is_store,
  output logic           is_wb,
  output logic           is_halt
);

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_wb    = 1'b0;
    is_halt  = 1'b0;
    case (op)
      OP_LW, OP_LH, OP_LB:                                  is_load  = 1'b1;
      OP_SW, OP_SH, OP_SB:                                  is_store = 1'b1;
      OP_R, OP_ADDI, OP_LUI, OP_ANDI, OP_ORI, OP_XORI,
      OP_JAL:                                               is_wb    = 1'b1;
      OP_HALT:                                              is_halt  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: owns pc, instruction register, write strobes
// and the busy-cycle / retired-instruction counters.
//
// state     | meaning
// IDLE      | out of reset, waiting for start
// FETCH     | imem_addr = pc presented
// DECODE    | instruction word captured into ins
// EXECUTE   | classify; simple ops retire here
// MEMORY    | store strobe (retire) or load read outstanding
// WRITEBACK | register-file write, retire
// HALT      | halt retired, state frozen until start
module core_sequencer
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] ins,
  output logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] nextpc,
  input  logic [REGW-1:0] wra,
  output logic            rf_we,
  output logic            dm_we,
  output logic            dm_re,
  output logic            busy,
  output logic            halted,
  output logic [XLEN-1:0] cycle_count,
  output logic [XLEN-1:0] instret
);

  state_t state, state_nx;
  logic   is_load, is_store, is_wb, is_halt;
  logic   start_ok, retire, pc_adv;

  op_classify u_op_classify (
    .op      (ins[31:26]),
    .is_load (is_load),
    .is_store(is_store),
    .is_wb   (is_wb),
    .is_halt (is_halt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_HALT: if (start) state_nx = ST_FETCH;
      ST_FETCH:         state_nx = ST_DECODE;
      ST_DECODE:        state_nx = ST_EXECUTE;
      ST_EXECUTE: begin
        if (is_halt)                  state_nx = ST_HALT;
        else if (is_load || is_store) state_nx = ST_MEMORY;
        else if (is_wb)               state_nx = ST_WRITEBACK;
        else                          state_nx = ST_FETCH;
      end
      ST_MEMORY:        state_nx = is_load ? ST_WRITEBACK : ST_FETCH;
      ST_WRITEBACK:     state_nx = ST_FETCH;
      default:          state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != ST_IDLE) && (state != ST_HALT);
    halted = (state == ST_HALT);
    rf_we  = (state == ST_WRITEBACK) && (wra != '0);
    dm_we  = (state == ST_MEMORY) && is_store;
    dm_re  = (state == ST_MEMORY) && is_load;
  end

  assign imem_addr = pc;
  assign start_ok  = start && ((state == ST_IDLE) || (state == ST_HALT));

  // Halt retires in EXECUTE but keeps pc pointing at itself.
  assign retire = ((state == ST_EXECUTE) && !is_load && !is_store && !is_wb)
                || ((state == ST_MEMORY) && is_store)
                || (state == ST_WRITEBACK);
  assign pc_adv = retire && !((state == ST_EXECUTE) && is_halt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      ins         <= '0;
      cycle_count <= '0;
      instret     <= '0;
    end else if (start_ok) begin
      pc          <= RESET_PC;
      cycle_count <= '0;
      instret     <= '0;
    end else begin
      if (busy)                 cycle_count <= cycle_count + 32'd1;
      if (state == ST_DECODE)   ins         <= imem_rdata;
      if (retire)               instret     <= instret + 32'd1;
      if (pc_adv)               pc          <= nextpc;
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: an instruction-level program model predicts every
// strobe/halt event; a monitor pops and compares as the DUT produces them.
module tb_core_sequencer;

  localparam int K_DMRE = 1;
  localparam int K_DMWE = 2;
  localparam int K_RFWE = 3;
  localparam int K_HALT = 4;

  typedef struct {
    int          kind;
    logic [31:0] pc;
    logic [31:0] cc;
    logic [31:0] ir;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] imem_addr, imem_rdata, ins, pc, nextpc;
  logic [4:0]  wra;
  logic        rf_we, dm_we, dm_re, busy, halted;
  logic [31:0] cycle_count, instret;

  logic [31:0] mem     [1024];
  logic [31:0] npc_tab [1024];
  logic [4:0]  wra_tab [1024];
  bit          used    [1024];
  logic [31:0] gpc;

  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_bad = 0;
  logic halted_q = 1'b0;

  core_sequencer #(.RESET_PC(32'd0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ins(ins), .pc(pc), .nextpc(nextpc), .wra(wra),
    .rf_we(rf_we), .dm_we(dm_we), .dm_re(dm_re),
    .busy(busy), .halted(halted),
    .cycle_count(cycle_count), .instret(instret)
  );

  // Execute-unit stand-in: next pc and destination are per-address table entries.
  assign imem_rdata = mem[imem_addr[9:0]];
  assign nextpc     = npc_tab[pc[9:0]];
  assign wra        = wra_tab[pc[9:0]];

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic mon_pop(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d at pc 0x%0h, expected no event", kind, pc);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", 32'(kind), 32'(e.kind));
    chk("event_pc", pc, e.pc);
    chk("event_cycle_count", cycle_count, e.cc);
    chk("event_instret", instret, e.ir);
  endtask

  always @(negedge clk) begin
    if (dm_re === 1'b1) mon_pop(K_DMRE);
    if (dm_we === 1'b1) mon_pop(K_DMWE);
    if (rf_we === 1'b1) mon_pop(K_RFWE);
    if (halted === 1'b1 && halted_q !== 1'b1) mon_pop(K_HALT);
    halted_q = halted;
  end

  task automatic new_prog();
    for (int i = 0; i < 1024; i++) used[i] = 1'b0;
    used[0] = 1'b1;
    gpc = 32'd0;
  endtask

  task automatic put(input logic [5:0] op, input logic [4:0] w, input logic [31:0] npc);
    mem[gpc[9:0]]     = {op, 26'($urandom)};
    wra_tab[gpc[9:0]] = w;
    npc_tab[gpc[9:0]] = npc;
    used[npc[9:0]]    = 1'b1;
    gpc = npc;
  endtask

  function automatic logic [31:0] fresh_pc();
    logic [31:0] n;
    if (gpc < 32'd1023 && !used[gpc[9:0] + 10'd1] && $urandom_range(0, 1) == 1) return gpc + 32'd1;
    do n = 32'($urandom_range(1, 1023)); while (used[n[9:0]]);
    return n;
  endfunction

  // Instruction-level reference: walks the program and lists the strobes
  // and the halt it must produce, stamped with expected busy-cycle and retire counts.
  task automatic run_model();
    logic [31:0] mpc = 32'd0;
    logic [31:0] cc  = 32'd0;
    logic [31:0] ret = 32'd0;
    logic [5:0]  op;
    for (int guard = 0; guard < 2000; guard++) begin
      op = mem[mpc[9:0]][31:26];
      if (op == 6'd63) begin
        ret++;
        exp_q.push_back('{K_HALT, mpc, cc + 32'd3, ret});
        return;
      end else if (op inside {6'd16, 6'd18, 6'd20}) begin
        exp_q.push_back('{K_DMRE, mpc, cc + 32'd3, ret});
        if (wra_tab[mpc[9:0]] != 5'd0) exp_q.push_back('{K_RFWE, mpc, cc + 32'd4, ret});
        cc += 32'd5;
      end else if (op inside {6'd24, 6'd26, 6'd28}) begin
        exp_q.push_back('{K_DMWE, mpc, cc + 32'd3, ret});
        cc += 32'd4;
      end else if (op inside {6'd0, 6'd1, 6'd3, 6'd4, 6'd5, 6'd6, 6'd41}) begin
        if (wra_tab[mpc[9:0]] != 5'd0) exp_q.push_back('{K_RFWE, mpc, cc + 32'd3, ret});
        cc += 32'd4;
      end else begin
        cc += 32'd3;
      end
      ret++;
      mpc = npc_tab[mpc[9:0]];
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("cycle_count_cleared", cycle_count, 32'd0);
    chk("instret_cleared", instret, 32'd0);
    chk("pc_at_reset_pc", pc, 32'd0);
  endtask

  task automatic wait_halt(input int budget, input bit poke);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (poke) start = (i == 5 || i == 6);
      if (halted) done = 1'b1;
    end
    start = 1'b0;
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL halt_timeout: halted=%0b after %0d cycles, expected 1", halted, budget);
    end
    @(negedge clk);
    chk("leftover_events", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic chk_reset_vals();
    chk("rst_pc", pc, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);
    chk("rst_ins", ins, 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_dm_we", 32'(dm_we), 32'd0);
    chk("rst_dm_re", 32'(dm_re), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_cycle_count", cycle_count, 32'd0);
    chk("rst_instret", instret, 32'd0);
  endtask

  initial begin
    int ops [22] = '{0, 1, 3, 4, 5, 6, 16, 18, 20, 24, 26, 28,
                     32, 33, 34, 35, 40, 41, 42, 7, 62, 50};
    bit seen;
    logic [5:0] op;
    logic [31:0] npc;

    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'd0; npc_tab[i] = 32'd0; wra_tab[i] = 5'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;

    // addi r1,r0,5 ; halt
    new_prog();
    put(6'd1, 5'd1, 32'd1);
    put(6'd63, 5'd0, 32'd0);
    run_model();
    do_start();
    wait_halt(100, 1'b0);
    chk("halt_instret", instret, 32'd2);
    chk("halt_cycle_count", cycle_count, 32'd7);

    // beq->3, sw, lw r7, addi r0, undefined 0x3E, beq->0x10, halt (restart from HALT)
    new_prog();
    put(6'd32, 5'd0, 32'd3);
    put(6'd24, 5'd0, 32'd4);
    put(6'd16, 5'd7, 32'd5);
    put(6'd1,  5'd0, 32'd6);
    put(6'd62, 5'd9, 32'd7);
    put(6'd32, 5'd0, 32'h10);
    put(6'd63, 5'd0, 32'd0);
    run_model();
    do_start();
    wait_halt(200, 1'b0);
    chk("prog2_instret", instret, 32'd7);
    chk("prog2_halt_pc", pc, 32'h10);

    // Randomized programs; some get a start pulse while busy
    for (int r = 0; r < 10; r++) begin
      new_prog();
      for (int k = 0; k < 24; k++) begin
        op  = 6'(ops[$urandom_range(0, 21)]);
        npc = fresh_pc();
        put(op, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), npc);
      end
      put(6'd63, 5'd0, 32'd0);
      run_model();
      do_start();
      wait_halt(400, r[0]);
    end

    // Reset during a store's MEMORY state, with start held high at the same edge
    new_prog();
    put(6'd24, 5'd0, 32'd1);
    put(6'd63, 5'd0, 32'd0);
    run_model();
    do_start();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (dm_we) seen = 1'b1;
    end
    chk("store_strobe_seen", 32'(seen), 32'd1);
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;
    start = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("idle_after_reset", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control FSM for the core's decode/execute datapath and the four byte-lane data memories. Each instruction passes through FETCH, DECODE, EXECUTE and then optionally MEMORY and/or WRITEBACK. The block owns the program counter, instruction register, write-enable strobes and performance counters. It sits between instruction memory, the decode/execute pair and the register file.

## Interface
- `RESET_PC`, 32'd0: word address loaded into `pc` on `start`.
- `clk` in 1: system clock, all state updates on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: begin execution; accepted only in IDLE or HALT.
- `imem_addr` out 32: instruction word address, equal to `pc`.
- `imem_rdata` in 32: instruction word, valid one cycle after `imem_addr`.
- `ins` out 32: instruction register driven to decode/execute.
- `pc` out 32: current instruction's word address.
- `nextpc` in 32: next PC computed by execute.
- `wra` in 5: destination register from execute.
- `rf_we` out 1: register-file write strobe.
- `dm_we` out 1: data-memory store qualifier, ANDed with the per-lane `wren` outside this block.
- `dm_re` out 1: high while a load's memory read is outstanding.
- `busy` out 1: high in any state except IDLE and HALT.
- `halted` out 1: high in HALT.
- `cycle_count` out 32: clocks spent busy.
- `instret` out 32: retired instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT.
- IDLE: outputs quiescent. On `start`, load `pc` with RESET_PC, clear both counters and go to FETCH.
- FETCH: present `imem_addr = pc`, then go to DECODE.
- DECODE: `ins <= imem_rdata`, then go to EXECUTE.
- EXECUTE: classify `ins[31:26]`:
  - 63 (halt): go to HALT and increment `instret`.
  - Loads 16/18/20 and stores 24/26/28: go to MEMORY.
  - Register writers 0/1/3/4/5/6/41: go to WRITEBACK.
  - Everything else (branches 32–35, jumps 40/42, undefined opcodes): `pc <= nextpc`, increment `instret`, go to FETCH. Undefined opcodes therefore behave as NOP.
- MEMORY:
  - Store: `dm_we=1` for exactly this cycle; `pc <= nextpc`, increment `instret`, go to FETCH.
  - Load: `dm_re=1`, go to WRITEBACK. Read data is valid in WRITEBACK.
- WRITEBACK: `rf_we = (wra != 0)`; `pc <= nextpc`, increment `instret`, go to FETCH.
- HALT: hold `pc`, `ins` and both counters. `start` restarts exactly as from IDLE.
- `start` is ignored while `busy`.
- `cycle_count` increments on every clock where `busy=1`. Both counters wrap modulo 2^32.
- `nextpc` and `wra` are sampled only in the states listed above and are never latched.

## Timing
- Reset (`rst_n=0` at an edge) produces: state IDLE, `pc=RESET_PC`, `ins=0`, `rf_we=dm_we=dm_re=0`, `busy=0`, `halted=0`, `cycle_count=0`, `instret=0`.
- Reset mid-instruction abandons it; no strobe is asserted in the cycle following that edge.
- Reset wins over a simultaneous `start`.
- Cycles per instruction, counted from FETCH entry to the next FETCH:
  - Branch, jump, NOP: 3.
  - ALU and `jal`: 4.
  - Store: 4.
  - Load: 5.
  - Halt: 3 cycles to HALT entry.
- `rf_we`, `dm_we` and `dm_re` are Moore outputs of the state and the registered `ins`. Each is a one-cycle pulse, never asserted twice per instruction.
- `start` sampled in IDLE puts the FSM in FETCH on the next edge, so `busy` rises one cycle after `start`.

## Structure
- Package `core_pkg` holds:
  - State enum.
  - Opcode constants: `OP_R=0`, `OP_ADDI=1`, `OP_LUI=3`, `OP_ANDI=4`, `OP_ORI=5`, `OP_XORI=6`, `OP_LW=16`, `OP_LH=18`, `OP_LB=20`, `OP_SW=24`, `OP_SH=26`, `OP_SB=28`, `OP_BEQ..OP_BLE=32..35`, `OP_J=40`, `OP_JAL=41`, `OP_JR=42`, `OP_HALT=63`.
  - Width constants.
- One combinational sub-module, `op_classify`: takes 6-bit op and outputs `is_load`, `is_store`, `is_wb`, `is_halt`. It is shared with later pipeline work.
- The FSM, PC/IR registers and counters live in `core_sequencer`.

## Test plan
- Reset, then `start` with RESET_PC=0 and the program `addi r1,r0,5` ; `halt`:
  - `rf_we` pulses once with `wra=1` in cycle 4.
  - `halted=1` after 7 busy cycles.
  - `instret=2`, `cycle_count=7`.
- `sw` at pc 3 followed by `lw`:
  - `dm_we` is high for exactly 1 cycle, in the store's MEMORY state.
  - The load shows `dm_re` in MEMORY, then `rf_we` in the next cycle.
  - The load takes 5 cycles.
- `beq` taken with `nextpc=0x10`: the next `imem_addr=0x10` appears 3 cycles after the branch's FETCH; `rf_we` and `dm_we` stay low throughout.
- `addi r0,r0,1`: WRITEBACK is entered but `rf_we` stays 0. Undefined opcode 0x3E retires in 3 cycles with `pc <= pc+1`.
- `rst_n=0` asserted during a store's MEMORY state: `dm_we` is 0 after the edge, and all outputs match their reset values. Pulsing `start` while busy has no effect.
- `start` in HALT: counters clear, `pc` returns to RESET_PC and `busy` rises on the next cycle.
